// File: rtl/lsu_wb.sv
// Load/store unit: turns one CPU memory request into one or more beats on a
// pipelined Wishbone B.4 master port, with misalignment and bus error handling.
module lsu_wb #(
    parameter int XLEN = 64,
    parameter int DW   = 16,
    parameter int SW   = DW / 8
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            start_i,
    input  logic            nomem_i,
    input  logic            we_i,
    input  logic [1:0]      size_i,
    input  logic            uns_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] dat_i,
    output logic            busy_o,
    output logic            rwe_o,
    output logic [XLEN-1:0] dat_o,
    output logic            mis_o,
    output logic            err_o,
    output logic [XLEN-1:0] wbmadr_o,
    output logic [DW-1:0]   wbmdat_o,
    output logic [SW-1:0]   wbmsel_o,
    output logic            wbmwe_o,
    output logic            wbmstb_o,
    output logic            wbmcyc_o,
    input  logic            wbmstall_i,
    input  logic            wbmack_i,
    input  logic            wbmerr_i,
    input  logic [DW-1:0]   wbmdat_i
);
    localparam int LSB = $clog2(SW);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic            uns_q, uns_d;
    logic [1:0]      size_q, size_d;
    logic [LSB-1:0]  off_q, off_d;
    logic [XLEN-1:0] base_q, base_d;
    logic [XLEN-1:0] wdat_q, wdat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [3:0]      n_q, n_d;
    logic [3:0]      iss_q, iss_d;
    logic [3:0]      ack_q, ack_d;
    logic [XLEN-1:0] asm_q, asm_d;
    logic [XLEN-1:0] dat_q, dat_d;
    logic            rwe_q, rwe_d;
    logic            mis_q, mis_d;
    logic            err_q, err_d;

    logic [3:0]      req_bytes;
    logic            req_mis;
    logic            req_sub;
    logic [3:0]      req_n;
    logic [SW-1:0]   req_sel;
    logic [XLEN-1:0] req_mask;
    logic [XLEN-1:0] req_wdat;

    // Request decode; store data is masked to its size and moved to its byte lane.
    always_comb begin
        req_bytes = 4'd1 << size_i;
        req_mis   = (addr_i[2:0] & 3'(req_bytes - 4'd1)) != 3'd0;
        req_sub   = {28'd0, req_bytes} < 32'(SW);
        req_n     = req_sub ? 4'd1 : 4'({28'd0, req_bytes} >> LSB);
        req_sel   = req_sub ? SW'(((16'd1 << req_bytes) - 16'd1) << addr_i[LSB-1:0]) : '1;
        req_mask  = (size_i == 2'd3) ? '1 : ((XLEN'(1) << {req_bytes, 3'b000}) - XLEN'(1));
        req_wdat  = we_i ? ((dat_i & req_mask) << {addr_i[LSB-1:0], 3'b000}) : '0;
    end

    logic            stb;
    logic            last_ack;
    logic [XLEN-1:0] full;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ext;

    always_comb begin
        stb      = (state_q == ACTIVE) && (iss_q < n_q);
        last_ack = wbmack_i && (ack_q == n_q - 4'd1);
        full     = asm_q | (XLEN'(wbmdat_i) << (32'(ack_q) * DW));
        lane     = full >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ext = uns_q ? XLEN'(lane[7:0])  : {{(XLEN-8){lane[7]}},   lane[7:0]};
            2'd1:    ext = uns_q ? XLEN'(lane[15:0]) : {{(XLEN-16){lane[15]}}, lane[15:0]};
            2'd2:    ext = uns_q ? XLEN'(lane[31:0]) : {{(XLEN-32){lane[31]}}, lane[31:0]};
            default: ext = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        size_d  = size_q;
        off_d   = off_q;
        base_d  = base_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        n_d     = n_q;
        iss_d   = iss_q;
        ack_d   = ack_q;
        asm_d   = asm_q;
        dat_d   = dat_q;
        rwe_d   = 1'b0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (nomem_i) begin
                        dat_d = addr_i;
                        rwe_d = 1'b1;
                    end else if (req_mis) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d = ACTIVE;
                        we_d    = we_i;
                        uns_d   = uns_i;
                        size_d  = size_i;
                        off_d   = addr_i[LSB-1:0];
                        base_d  = addr_i & ~XLEN'(SW - 1);
                        wdat_d  = req_wdat;
                        sel_d   = req_sel;
                        n_d     = req_n;
                        iss_d   = 4'd0;
                        ack_d   = 4'd0;
                        asm_d   = '0;
                    end
                end
            end
            ACTIVE: begin
                if (stb && !wbmstall_i) iss_d = iss_q + 4'd1;
                // An error wins over a coincident ack; partial load data is dropped.
                if (wbmerr_i) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    iss_d   = 4'd0;
                    ack_d   = 4'd0;
                    asm_d   = '0;
                end else if (wbmack_i) begin
                    ack_d = ack_q + 4'd1;
                    asm_d = full;
                    if (last_ack) begin
                        state_d = IDLE;
                        iss_d   = 4'd0;
                        ack_d   = 4'd0;
                        asm_d   = '0;
                        if (!we_q) begin
                            dat_d = ext;
                            rwe_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            off_q   <= '0;
            base_q  <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            n_q     <= 4'd0;
            iss_q   <= 4'd0;
            ack_q   <= 4'd0;
            asm_q   <= '0;
            dat_q   <= '0;
            rwe_q   <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            off_q   <= off_d;
            base_q  <= base_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            n_q     <= n_d;
            iss_q   <= iss_d;
            ack_q   <= ack_d;
            asm_q   <= asm_d;
            dat_q   <= dat_d;
            rwe_q   <= rwe_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign busy_o   = (state_q == ACTIVE);
    assign wbmcyc_o = (state_q == ACTIVE);
    assign wbmstb_o = stb;
    assign wbmwe_o  = stb && we_q;
    assign wbmsel_o = stb ? sel_q : '0;
    assign wbmadr_o = stb ? (base_q + (XLEN'(iss_q) << LSB)) : '0;
    assign wbmdat_o = stb ? DW'(wdat_q >> (32'(iss_q) * DW)) : '0;
    assign dat_o    = dat_q;
    assign rwe_o    = rwe_q;
    assign mis_o    = mis_q;
    assign err_o    = err_q;

endmodule
